// File: rtl/fetch_stage.sv
// fetch_stage: MIPS IF stage holding the PC and the IF/ID register, with stall/branch/flush handling and perf counters
module fetch_stage #(
    parameter int                  WORD_LEN = 32,
    parameter logic [WORD_LEN-1:0] RESET_PC = '0,
    parameter int                  CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                flush,
    input  logic                br_taken,
    input  logic [WORD_LEN-1:0] br_target,
    output logic [WORD_LEN-1:0] imem_addr,
    input  logic [WORD_LEN-1:0] imem_instr,
    output logic [WORD_LEN-1:0] ifid_pc4,
    output logic [WORD_LEN-1:0] ifid_instr,
    output logic                ifid_valid,
    output logic                pc_misalign,
    output logic [CNT_W-1:0]    fetch_count,
    output logic [CNT_W-1:0]    stall_count
);
    logic [WORD_LEN-1:0] pc_q, pc_d, pc4_q, pc4_d, instr_q, instr_d, pc_plus4;
    logic                valid_q, valid_d, mis_q, mis_d, bubble;
    logic [CNT_W-1:0]    fetch_q, fetch_d, stall_q, stall_d;

    always_comb begin
        pc_plus4 = pc_q + WORD_LEN'(4);
        bubble   = br_taken | flush;
        pc_d     = stall ? pc_q : br_taken ? {br_target[WORD_LEN-1:2], 2'b00} : pc_plus4;
        instr_d  = stall ? instr_q : bubble ? '0 : imem_instr;
        pc4_d    = stall ? pc4_q : bubble ? '0 : pc_plus4;
        valid_d  = stall ? valid_q : !bubble;
        mis_d    = mis_q | (!stall & br_taken & (|br_target[1:0]));
        fetch_d  = (!stall && !bubble) ? fetch_q + CNT_W'(1) : fetch_q;
        stall_d  = stall ? stall_q + CNT_W'(1) : stall_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            pc4_q   <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
            fetch_q <= '0;
            stall_q <= '0;
        end else begin
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            mis_q   <= mis_d;
            fetch_q <= fetch_d;
            stall_q <= stall_d;
        end
    end

    assign imem_addr   = pc_q;
    assign ifid_pc4    = pc4_q;
    assign ifid_instr  = instr_q;
    assign ifid_valid  = valid_q;
    assign pc_misalign = mis_q;
    assign fetch_count = fetch_q;
    assign stall_count = stall_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vector table plus hand-written reset/misalign sequences for fetch_stage
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst, stall, flush, br_taken;
    logic [31:0] br_target, imem_addr, imem_instr, ifid_pc4, ifid_instr;
    logic        ifid_valid, pc_misalign;
    logic [31:0] fetch_count, stall_count;
    int          passed = 0, total = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0C411800;
            32'h4:   return 32'h15022800;
            32'h14:  return 32'hA0A60000;
            default: return {16'hA5A5, a[15:0]};
        endcase
    endfunction

    assign imem_instr = imem(imem_addr);

    fetch_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .br_taken(br_taken),
        .br_target(br_target), .imem_addr(imem_addr), .imem_instr(imem_instr),
        .ifid_pc4(ifid_pc4), .ifid_instr(ifid_instr), .ifid_valid(ifid_valid),
        .pc_misalign(pc_misalign), .fetch_count(fetch_count), .stall_count(stall_count)
    );

    typedef struct {
        logic        st, fl, br;
        logic [31:0] tgt, addr, instr, pc4;
        logic        valid, mis;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    task automatic step(input logic r, input logic s, input logic f, input logic b, input logic [31:0] t);
        rst = r; stall = s; flush = f; br_taken = b; br_target = t;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [31:0] a, input logic [31:0] i,
                             input logic [31:0] p, input logic v, input logic m);
        chk({tag, ".addr"}, imem_addr, a);
        chk({tag, ".instr"}, ifid_instr, i);
        chk({tag, ".pc4"}, ifid_pc4, p);
        chk({tag, ".valid"}, {31'b0, ifid_valid}, {31'b0, v});
        chk({tag, ".mis"}, {31'b0, pc_misalign}, {31'b0, m});
    endtask

    vec_t vt[15];

    initial begin
        vt[0]  = '{0,0,0,0,        32'h4,        32'h0C411800, 32'h4,  1,0};
        vt[1]  = '{0,0,0,0,        32'h8,        32'h15022800, 32'h8,  1,0};
        vt[2]  = '{1,0,0,0,        32'h8,        32'h15022800, 32'h8,  1,0};
        vt[3]  = '{1,0,0,0,        32'h8,        32'h15022800, 32'h8,  1,0};
        vt[4]  = '{1,1,1,32'h14,   32'h8,        32'h15022800, 32'h8,  1,0};
        vt[5]  = '{0,0,0,0,        32'hC,        32'hA5A50008, 32'hC,  1,0};
        vt[6]  = '{0,1,1,32'h14,   32'h14,       32'h0,        32'h0,  0,0};
        vt[7]  = '{0,0,0,0,        32'h18,       32'hA0A60000, 32'h18, 1,0};
        vt[8]  = '{0,1,0,32'h40,   32'h1C,       32'h0,        32'h0,  0,0};
        vt[9]  = '{0,0,0,0,        32'h20,       32'hA5A5001C, 32'h20, 1,0};
        vt[10] = '{0,0,1,32'hFFFFFFFC, 32'hFFFFFFFC, 32'h0,   32'h0,  0,0};
        vt[11] = '{0,0,0,0,        32'h0,        32'hA5A5FFFC, 32'h0,  1,0};
        vt[12] = '{0,0,1,32'h17,   32'h14,       32'h0,        32'h0,  0,1};
        vt[13] = '{0,0,0,0,        32'h18,       32'hA0A60000, 32'h18, 1,1};
        vt[14] = '{0,0,0,0,        32'h1C,       32'hA5A50018, 32'h1C, 1,1};

        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk_state("reset", 32'h0, 32'h0, 32'h0, 0, 0);
        chk("reset.fetch_count", fetch_count, 0);
        chk("reset.stall_count", stall_count, 0);

        for (int i = 0; i < 15; i++) begin
            step(0, vt[i].st, vt[i].fl, vt[i].br, vt[i].tgt);
            chk_state($sformatf("vec%0d", i), vt[i].addr, vt[i].instr, vt[i].pc4, vt[i].valid, vt[i].mis);
            if (i == 1) chk("two_fetches.fetch_count", fetch_count, 2);
            if (i == 3) chk("two_stalls.stall_count", stall_count, 2);
        end
        chk("table.fetch_count", fetch_count, 8);
        chk("table.stall_count", stall_count, 3);

        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0, 0, 0);
            chk($sformatf("sticky%0d.mis", i), {31'b0, pc_misalign}, 32'h1);
        end
        chk("sticky.addr", imem_addr, 32'h1C + 32'd80);
        chk("sticky.fetch_count", fetch_count, 28);

        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
        chk("pre_pulse.addr", imem_addr, 32'h10);
        step(1, 1, 1, 1, 32'h44);
        chk_state("pulse", 32'h0, 32'h0, 32'h0, 0, 0);
        chk("pulse.fetch_count", fetch_count, 0);
        chk("pulse.stall_count", stall_count, 0);
        step(0, 0, 0, 0, 0);
        chk_state("restart", 32'h4, 32'h0C411800, 32'h4, 1, 0);
        chk("restart.fetch_count", fetch_count, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
